// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and default widths for the unified-memory arbiter.
// ERR_I/ERR_D exist only when MEM_ARB_ALIGN_CHK_EN is defined.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2
`ifdef MEM_ARB_ALIGN_CHK_EN
    ,
    ERR_I  = 3'd3,
    ERR_D  = 3'd4
`endif
  } arb_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts BUSY cycles without a memory completion; expire marks the
// TIMEOUT-th such cycle.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory.
// MEM_ARB_ALIGN_CHK_EN adds a misaligned-address error path.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  arb_state_e state_q, state_d;

  logic              drop_q;
  logic              gnt_d, gnt_i, gnt;
  logic              busy, expire;
  logic              hit_i, hit_d;
  logic              misalign, err_i, err_d;
  logic [ADDR_W-1:0] gnt_addr;

  // Data side wins: it belongs to the older instruction.
  assign gnt_d    = (state_q == IDLE) && d_req;
  assign gnt_i    = (state_q == IDLE) && !d_req
                 && if_req && !if_flush;
  assign gnt      = gnt_d || gnt_i;
  assign gnt_addr = gnt_d ? d_addr : if_addr;
  assign busy     = (state_q == BUSY_I)
                 || (state_q == BUSY_D);

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign misalign = gnt_addr[0];
  assign err_i    = (state_q == ERR_I);
  assign err_d    = (state_q == ERR_D);
`else
  assign misalign = 1'b0;
  assign err_i    = 1'b0;
  assign err_d    = 1'b0;
`endif

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (gnt),
    .enable (busy && !mem_done),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_d:   state_d = BUSY_D;
          gnt_i:   state_d = BUSY_I;
          default: state_d = IDLE;
        endcase
`ifdef MEM_ARB_ALIGN_CHK_EN
        if (gnt && misalign) begin
          state_d = gnt_d ? ERR_D : ERR_I;
        end
`endif
      end
      BUSY_I, BUSY_D: begin
        if (mem_done || expire) begin
          state_d = IDLE;
        end
      end
`ifdef MEM_ARB_ALIGN_CHK_EN
      ERR_I, ERR_D: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= (state_q == BUSY_I)
              && (state_d == BUSY_I)
              && (drop_q || if_flush);
      mem_en  <= gnt && !misalign;
      err     <= err || expire
              || err_i || err_d;
      if (gnt) begin
        mem_wr    <= gnt_d && d_wr;
        mem_addr  <= gnt_addr;
        mem_wdata <= gnt_d ? d_wdata : '0;
      end
    end
  end

  // A flush in the completion cycle also cancels the fetch.
  assign hit_i = (state_q == BUSY_I) && mem_done
              && !drop_q && !if_flush;
  assign hit_d = (state_q == BUSY_D) && mem_done;

  assign if_done   = hit_i || err_i;
  assign d_done    = hit_d || err_d;
  assign if_rdata  = hit_i ? mem_rdata : '0;
  assign d_rdata   = (hit_d && !mem_wr)
                   ? mem_rdata : '0;
  assign stall_if  = if_req && !if_done;
  assign stall_mem = d_req && !d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed corner cases, then random
// fetch/data traffic against a reference memory with random latency.
module tb_mem_arbiter;

  localparam int TO  = 4;
  localparam int NTX = 150;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, d_req, d_wr, mem_done;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_done, d_done, stall_if, stall_mem;
  logic        mem_en, mem_wr, err;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int   checks   = 0;
  int   failures = 0;
  logic stop     = 1'b0;

  logic [15:0] fq[$];
  logic [15:0] dq[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] dref[logic [15:0]];

  mem_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic data_agent();
    for (int t = 0; t < NTX; t++) begin
      logic [15:0] a, e;
      int n;
      tick();
      if ($urandom_range(0, 3) == 0) begin
        d_req = 1'b0;
        continue;
      end
      a       = 16'($urandom_range(0, 7) * 2);
      d_addr  = a;
      d_wr    = 1'($urandom_range(0, 1));
      d_wdata = 16'($urandom);
      if (d_wr) begin
        e       = 16'h0;
        dref[a] = d_wdata;
      end else begin
        e = dref.exists(a) ? dref[a] : init_val(a);
      end
      dq.push_back(e);
      d_req = 1'b1;
      n = 0;
      do begin
        smp();
        n++;
      end while (!d_done && n < 60);
      if (!d_done) begin
        check("d_liveness", d_done, 1);
        dq.delete();
      end
    end
    tick();
    d_req = 1'b0;
  endtask

  task automatic fetch_agent();
    for (int t = 0; t < NTX; t++) begin
      logic [15:0] a;
      int n;
      bit fin;
      tick();
      if_flush = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        if_req = 1'b0;
        continue;
      end
      a       = 16'h8000 | 16'($urandom_range(0, 255) * 2);
      if_addr = a;
      if_req  = 1'b1;
      fq.push_back(init_val(a));
      n   = 0;
      fin = 1'b0;
      while (!fin) begin
        smp();
        n++;
        if (if_done) begin
          fin = 1'b1;
        end else if (n >= 60) begin
          check("if_liveness", if_done, 1);
          fq.delete();
          fin = 1'b1;
        end else if ($urandom_range(0, 9) == 0) begin
          tick();
          if_req   = 1'b0;
          if_flush = 1'b1;
          void'(fq.pop_back());
          fin = 1'b1;
        end
      end
    end
    tick();
    if_req   = 1'b0;
    if_flush = 1'b0;
  endtask

  task automatic mem_agent();
    while (!stop) begin
      smp();
      if (mem_en) begin
        logic [15:0] a;
        logic w;
        int lat;
        a = mem_addr;
        w = mem_wr;
        if (w) mem[a] = mem_wdata;
        lat = $urandom_range(1, 3);
        repeat (lat) @(posedge clk);
        #1;
        mem_done  = 1'b1;
        mem_rdata = w ? 16'($urandom)
                  : (mem.exists(a) ? mem[a] : init_val(a));
        tick();
        mem_done  = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  endtask

  task automatic monitor();
    bit          out   = 1'b0;
    bit          own_i = 1'b0;
    bit          canc  = 1'b0;
    logic        p_d   = 1'b0;
    logic        p_i   = 1'b0;
    logic        p_dw  = 1'b0;
    logic [15:0] p_da  = '0;
    logic [15:0] p_dwd = '0;
    logic [15:0] p_ia  = '0;
    logic [15:0] e;
    while (!stop) begin
      smp();
      if (mem_en) begin
        check("one_outstanding", 32'(out), 0);
        if (p_d) begin
          check("cmd_d_addr", mem_addr, p_da);
          check("cmd_d_wr", mem_wr, p_dw);
          if (p_dw) check("cmd_d_wdata", mem_wdata, p_dwd);
          own_i = 1'b0;
        end else begin
          check("cmd_i_pending", p_i, 1);
          check("cmd_i_addr", mem_addr, p_ia);
          check("cmd_i_wr", mem_wr, 0);
          own_i = 1'b1;
        end
        out  = 1'b1;
        canc = 1'b0;
      end
      if (out && own_i && if_flush) canc = 1'b1;
      if (mem_done && out) begin
        check("done_pulse", {if_done, d_done},
              {own_i && !canc, !own_i});
        out = 1'b0;
      end else begin
        check("no_done", {if_done, d_done}, 0);
      end
      if (if_done) begin
        if (fq.size() == 0) begin
          check("if_unexpected", if_done, 0);
        end else begin
          e = fq.pop_front();
          check("if_rdata", if_rdata, e);
        end
      end
      if (d_done) begin
        if (dq.size() == 0) begin
          check("d_unexpected", d_done, 0);
        end else begin
          e = dq.pop_front();
          check("d_rdata", d_rdata, e);
        end
      end
      check("err_clear", err, 0);
      p_d   = d_req;
      p_da  = d_addr;
      p_dw  = d_wr;
      p_dwd = d_wdata;
      p_i   = if_req && !if_flush;
      p_ia  = if_addr;
    end
    check("fq_drained", fq.size(), 0);
    check("dq_drained", dq.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_flush  = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_wr      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_done  = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    smp();
    check("rst_ctl", {mem_en, mem_wr, if_done, d_done,
                      err, stall_if, stall_mem}, 0);
    check("rst_cmd", {mem_addr, mem_wdata}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    tick();
    rst_n = 1'b1;

    // plain load, mem_done two cycles after mem_en
    tick();
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0040;
    smp();
    check("load_grant_cycle", mem_en, 0);
    check("load_stall", stall_mem, 1);
    tick();
    smp();
    check("load_mem_en", mem_en, 1);
    check("load_addr", mem_addr, 16'h0040);
    check("load_wr", mem_wr, 0);
    tick();
    smp();
    check("load_en_pulse", {mem_en, d_done}, 0);
    tick();
    mem_done  = 1'b1;
    mem_rdata = 16'hBEEF;
    smp();
    check("load_done", d_done, 1);
    check("load_rdata", d_rdata, 16'hBEEF);
    check("load_stall_fall", stall_mem, 0);
    tick();
    mem_done  = 1'b0;
    mem_rdata = 16'h0;
    d_req     = 1'b0;
    smp();
    check("load_done_pulse", d_done, 0);

    // contention: store first, then the fetch
    tick();
    if_req  = 1'b1;
    if_addr = 16'h0100;
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0042;
    d_wdata = 16'h1357;
    tick();
    smp();
    check("cont_d_first", {mem_en, mem_wr}, 2'b11);
    check("cont_d_addr", mem_addr, 16'h0042);
    check("cont_d_wdata", mem_wdata, 16'h1357);
    tick();
    mem_done  = 1'b1;
    mem_rdata = 16'hFFFF;
    smp();
    check("cont_d_done", {if_done, d_done}, 2'b01);
    check("cont_store_rdata", d_rdata, 0);
    check("cont_if_stall", stall_if, 1);
    tick();
    mem_done = 1'b0;
    d_req    = 1'b0;
    d_wr     = 1'b0;
    smp();
    check("cont_i_grant_cycle", mem_en, 0);
    tick();
    smp();
    check("cont_i_mem_en", {mem_en, mem_wr}, 2'b10);
    check("cont_i_addr", mem_addr, 16'h0100);

    // redirect while the fetch is in flight
    tick();
    if_req   = 1'b0;
    if_flush = 1'b1;
    smp();
    check("flush_no_done", if_done, 0);
    tick();
    if_flush  = 1'b0;
    if_req    = 1'b1;
    if_addr   = 16'h0200;
    mem_done  = 1'b1;
    mem_rdata = 16'hAAAA;
    smp();
    check("flush_dropped", {if_done, if_rdata}, 0);
    tick();
    mem_done = 1'b0;
    smp();
    check("flush_regrant_cycle", mem_en, 0);
    tick();
    smp();
    check("flush_new_en", mem_en, 1);
    check("flush_new_addr", mem_addr, 16'h0200);
    tick();
    mem_done  = 1'b1;
    mem_rdata = 16'h5555;
    smp();
    check("fetch_done", if_done, 1);
    check("fetch_rdata", if_rdata, 16'h5555);
    check("fetch_stall_fall", stall_if, 0);
    tick();
    mem_done = 1'b0;
    if_req   = 1'b0;

    // timeout: no mem_done for TO busy cycles
    tick();
    d_req  = 1'b1;
    d_addr = 16'h0010;
    tick();
    smp();
    check("to_mem_en", mem_en, 1);
    repeat (3) begin
      tick();
      smp();
    end
    check("to_not_yet", err, 0);
    tick();
    smp();
    check("to_err", err, 1);
    check("to_idle", {mem_en, d_done, stall_mem}, 3'b001);
    tick();
    smp();
    check("to_reissue", mem_en, 1);
    tick();
    mem_done  = 1'b1;
    mem_rdata = 16'h0777;
    smp();
    check("to_retry_done", d_done, 1);
    check("to_retry_rdata", d_rdata, 16'h0777);
    tick();
    mem_done = 1'b0;
    d_req    = 1'b0;
    repeat (3) tick();
    smp();
    check("to_err_sticky", err, 1);

    // reset in the middle of a transaction
    tick();
    d_req  = 1'b1;
    d_addr = 16'h0020;
    tick();
    smp();
    check("rmid_mem_en", mem_en, 1);
    tick();
    rst_n = 1'b0;
    d_req = 1'b0;
    smp();
    check("rmid_ctl", {mem_en, mem_wr, if_done, d_done, err}, 0);
    check("rmid_cmd", {mem_addr, mem_wdata}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_done  = 1'b1;
    mem_rdata = 16'h1111;
    smp();
    check("rmid_late_done", {d_done, if_done, mem_en, err}, 0);
    check("rmid_rdata", {d_rdata, if_rdata}, 0);
    tick();
    mem_done = 1'b0;

    fork
      begin
        fork
          fetch_agent();
          data_agent();
        join
        repeat (8) tick();
        stop = 1'b1;
      end
      mem_agent();
      monitor();
    join

`ifdef MEM_ARB_ALIGN_CHK_EN
    tick();
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0041;
    tick();
    smp();
    check("align_no_en", mem_en, 0);
    check("align_done", d_done, 1);
    check("align_rdata", d_rdata, 0);
    tick();
    d_req = 1'b0;
    smp();
    check("align_err", err, 1);
    check("align_still_no_en", mem_en, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
